// File: rtl/ram_8k.sv
// ram_8k: 8192 x 16-bit word-addressed RAM built from eight 1024-word banks.
// Writes are synchronous, reads are combinational, and a synchronous reset
// clears every word in a single clock cycle.

// ram_8k_bank: one 1024 x 16-bit bank with synchronous clear and async read.
module ram_8k_bank (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [9:0]  address,
    input  logic [15:0] in,
    output logic [15:0] out
);

    logic [15:0] mem [1024];

    // Clear the whole bank on reset (reset beats load), otherwise store on load.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 1024; i++) begin
                mem[i] <= 16'h0000;
            end
        end else if (load) begin
            mem[address] <= in;
        end
    end

    assign out = mem[address];

endmodule

// ram_8k: address[12:10] picks the bank, address[9:0] the word inside it.
module ram_8k (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] in,
    input  logic        load,
    input  logic [12:0] address,
    output logic [15:0] out
);

    logic [2:0]  bank_sel;
    logic [9:0]  word_sel;
    logic [7:0]  bank_load;
    logic [15:0] bank_out [8];

    assign bank_sel = address[12:10];
    assign word_sel = address[9:0];

    // Route the write enable to the selected bank only; the rest see load=0.
    always_comb begin
        bank_load           = 8'h00;
        bank_load[bank_sel] = load;
    end

    for (genvar g = 0; g < 8; g++) begin : g_bank
        ram_8k_bank u_bank (
            .clk     (clk),
            .reset   (reset),
            .load    (bank_load[g]),
            .address (word_sel),
            .in      (in),
            .out     (bank_out[g])
        );
    end

    assign out = bank_out[bank_sel];

endmodule

// File: tb/tb_ram_8k.sv
// tb_ram_8k: directed self-checking bench for ram_8k.
module tb_ram_8k;

    logic        clk;
    logic        reset;
    logic [15:0] data_in;
    logic        load;
    logic [12:0] address;
    logic [15:0] data_out;

    int total_checks = 0;
    int bad_checks   = 0;

    int written_addrs[$];

    ram_8k dut (
        .clk     (clk),
        .reset   (reset),
        .in      (data_in),
        .load    (load),
        .address (address),
        .out     (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value with its expected value and count it.
    task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total_checks++;
        if (got !== exp) begin
            bad_checks++;
            $display("[TB] FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Write one word on the next rising edge, then drop load just after it.
    task automatic applyStimulus(input logic [12:0] a, input logic [15:0] d);
        @(negedge clk);
        address = a;
        data_in = d;
        load    = 1'b1;
        @(posedge clk);
        #1;
        load = 1'b0;
        written_addrs.push_back(int'(a));
    endtask

    // Select an address, let the combinational read settle, and check it.
    task automatic readCheck(input string tag, input logic [12:0] a, input logic [15:0] exp);
        address = a;
        #1;
        checkOutput($sformatf("%s@%0d", tag, a), data_out, exp);
    endtask

    int big_addrs[13] = '{500, 1000, 1505, 2022, 2500, 3050, 3600, 4196,
                          5200, 6666, 7777, 8090, 8091};
    int nb_addrs[9]   = '{501, 1001, 1506, 2023, 3599, 4195, 5201, 6667, 7778};

    initial begin
        reset   = 1'b1;
        load    = 1'b0;
        data_in = 16'h0000;
        address = 13'd0;

        // One reset cycle
        @(posedge clk);
        #1;
        reset = 1'b0;
        readCheck("reset_zero", 13'd0, 16'h0000);
        readCheck("reset_zero", 13'd8191, 16'h0000);

        // First write: addr 0 <= 1, visible with no extra clock
        applyStimulus(13'd0, 16'd1);
        checkOutput("same_cycle_read@0", data_out, 16'd1);
        readCheck("neighbour", 13'd1, 16'h0000);
        readCheck("readback", 13'd0, 16'd1);

        // value = address across all banks
        foreach (big_addrs[i]) applyStimulus(13'(big_addrs[i]), 16'(big_addrs[i]));
        foreach (big_addrs[i]) readCheck("val_eq_addr", 13'(big_addrs[i]), 16'(big_addrs[i]));
        foreach (nb_addrs[i])  readCheck("neighbour", 13'(nb_addrs[i]), 16'h0000);

        // Full-scale values and a bank boundary
        applyStimulus(13'd8191, 16'hFFFF);
        applyStimulus(13'd1024, 16'h8000);
        readCheck("top_word", 13'd8191, 16'hFFFF);
        readCheck("bank_boundary", 13'd1024, 16'h8000);
        readCheck("below_boundary", 13'd1023, 16'h0000);

        // load=0 for several edges must not disturb addr 500
        @(negedge clk);
        address = 13'd500;
        data_in = 16'h1234;
        load    = 1'b0;
        for (int e = 0; e < 4; e++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("hold_e%0d", e), data_out, 16'd500);
        end

        // in changes mid-cycle: only the value at the edge is stored
        @(negedge clk);
        address = 13'd600;
        data_in = 16'hAAAA;
        load    = 1'b1;
        #2;
        checkOutput("pre_edge@600", data_out, 16'h0000);
        data_in = 16'h5555;
        @(posedge clk);
        #1;
        load    = 1'b0;
        data_in = 16'hAAAA;
        #1;
        checkOutput("edge_value@600", data_out, 16'h5555);
        written_addrs.push_back(600);

        // load pulse that ends before the edge must not write
        @(negedge clk);
        address = 13'd700;
        data_in = 16'h1111;
        load    = 1'b1;
        #2;
        load = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("glitch_load@700", data_out, 16'h0000);

        // Back-to-back writes to one address keep the last value
        applyStimulus(13'd900, 16'h0111);
        applyStimulus(13'd900, 16'h0222);
        readCheck("back_to_back", 13'd900, 16'h0222);
        readCheck("independent", 13'd1505, 16'd1505);

        // Reset with a simultaneous write: reset wins, everything clears
        @(negedge clk);
        reset   = 1'b1;
        load    = 1'b1;
        data_in = 16'd7;
        address = 13'd5;
        @(posedge clk);
        #1;
        reset = 1'b0;
        load  = 1'b0;
        checkOutput("reset_beats_load@5", data_out, 16'h0000);
        foreach (written_addrs[i]) readCheck("after_reset", 13'(written_addrs[i]), 16'h0000);

        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end

    // Watchdog so the run always ends on its own
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got=timeout expected=finish");
        bad_checks++;
        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end

endmodule

// File: doc/ram_8k.md
RAM_8K -- requirements
Module: ram_8k

Interface
REQ-001 The block SHALL expose the ports below (clock and reset first); one clock, reset synchronous and active-high.
REQ-002 clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous active-high reset, sampled on rising clk.
REQ-004 in  input  16  data word to write (two's-complement, treated as raw bits).
REQ-005 load  input  1  write enable; 1 = write `in` to `address` on the next rising clk.
REQ-006 address  input  13  word address, 0..8191.
REQ-007 out  output  16  contents of the word currently selected by `address`.
REQ-008 The block SHALL have no parameters; depth is fixed at 8192 words and width at 16 bits.

Function
REQ-009 Storage SHALL be 8192 independent 16-bit words, one per address value; every address 0..8191 SHALL be valid and distinct.
REQ-010 Storage SHALL be organised as 8 banks of 1024 words; address[12:10] selects the bank and address[9:0] selects the word within it.
REQ-011 On a rising clk with reset=0 and load=1, the selected word SHALL take the value of `in`; all other words SHALL hold.
REQ-012 On a rising clk with reset=0 and load=0, no word SHALL change.
REQ-013 Only the bank selected by address[12:10] SHALL receive the write enable; the other seven banks SHALL see load=0.
REQ-014 `out` SHALL be a combinational read: out = word[address] at all times, with zero-cycle read latency on an address change.
REQ-015 After a write edge, `out` SHALL show the newly written value in the same cycle, without a further clock, while `address` is unchanged.
REQ-016 Changes on `in` or `load` between clock edges SHALL NOT alter storage; only values present at the rising edge count.
REQ-017 Back-to-back writes on consecutive edges to the same address SHALL leave the last value; writes to different addresses SHALL be independent.
REQ-018 Values SHALL be stored and returned bit-exact, including bit 15; the block SHALL perform no sign handling or arithmetic.

Reset
REQ-019 On a rising clk with reset=1, every one of the 8192 words SHALL become 0x0000, whatever the value of load.
REQ-020 A write requested in the same cycle as reset SHALL be discarded; reset has priority.
REQ-021 After reset, `out` SHALL read 0x0000 for every address until that address is written.
REQ-022 Reset asserted between a write and a read SHALL cause the read to return 0x0000.
REQ-023 Before the first reset, contents are undefined; the bench SHALL NOT check unwritten, unreset words.

Verification
REQ-024 The bench SHALL cover: reset 1 cycle; then load=1, addr 0, in=1 on one edge -> out=1 at addr 0; addr 1 -> 0.
REQ-025 The bench SHALL cover: writes of value=address at 500, 1000, 1505, 2022, 2500, 3050, 3600, 4196, 5200, 6666, 7777, 8090, 8091, then load=0 -> each reads back its value; neighbours 501, 1001, 1506, 2023, 3599, 4195, 5201, 6667, 7778 read 0.
REQ-026 The bench SHALL cover: write 0xFFFF at addr 8191, 0x8000 at addr 1024 (bank boundary) -> exact values read back; addr 1023 reads 0.
REQ-027 The bench SHALL cover: load=0 with in=0x1234 for several edges at addr 500 -> out stays 500.
REQ-028 The bench SHALL cover: reset=1 with load=1, in=7, addr 5 -> addr 5 reads 0 and all previously written addresses read 0.
REQ-029 The bench SHALL cover: changing `in` mid-cycle with load=1 -> only the value present at the rising edge is stored.
